// File: rtl/sysid_pkg.sv
// Shared definitions for the system-ID slave and its checker: FSM encoding,
// word offsets and the expected ID/timestamp both sides are generated from.
package sysid_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ_ID,
    ST_LAT_ID,
    ST_REQ_TS,
    ST_LAT_TS,
    ST_FIN
  } sysid_state_t;

  localparam logic SYSID_ID_OFS = 1'b0;
  localparam logic SYSID_TS_OFS = 1'b1;

  localparam logic [31:0] SYSID_DEFAULT_ID = 32'd0;
  localparam logic [31:0] SYSID_DEFAULT_TS = 32'd1427079909;

  // A word that was never captured (skipped after a timeout) never matches.
  function automatic logic word_match(input logic valid,
                                      input logic [31:0] got,
                                      input logic [31:0] expected);
    return valid && (got == expected);
  endfunction

endpackage

// File: rtl/avm_single_read.sv
// Single-word Avalon-MM read engine: acceptance detect, stall/timeout counter
// and a capture strobe delayed by the fixed slave read latency.
module avm_single_read #(
  parameter int unsigned READ_LATENCY = 0,
  parameter int unsigned TIMEOUT      = 255
) (
  input  logic clock,
  input  logic reset,
  input  logic req,
  input  logic lat,
  input  logic waitrequest,
  output logic accept,
  output logic capture,
  output logic timeout
);

  localparam logic [15:0] STALL_LAST = 16'(TIMEOUT - 1);
  localparam logic [1:0]  LAT_LAST   = (READ_LATENCY == 0) ? 2'd0 : 2'(READ_LATENCY - 1);

  logic [15:0] stall_cnt;
  logic [1:0]  lat_cnt;

  // Cleared whenever no request is pending and on acceptance, so back-to-back
  // requests (zero latency) each start from a fresh count.
  always_ff @(posedge clock) begin
    if (reset || !req || accept) begin
      stall_cnt <= '0;
    end else if (waitrequest) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset || !lat) begin
      lat_cnt <= '0;
    end else begin
      lat_cnt <= lat_cnt + 2'd1;
    end
  end

  always_comb begin
    accept  = req && !waitrequest;
    timeout = req && waitrequest && (stall_cnt == STALL_LAST);
    if (READ_LATENCY == 0) begin
      capture = accept;
    end else begin
      capture = lat && (lat_cnt == LAT_LAST);
    end
  end

endmodule

// File: rtl/sysid_checker.sv
// Reads system ID and build timestamp from the sysid slave after reset or on
// request and reports whether both match the values this build expects.
module sysid_checker
  import sysid_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID  = SYSID_DEFAULT_ID,
  parameter logic [31:0] EXPECTED_TS  = SYSID_DEFAULT_TS,
  parameter int unsigned READ_LATENCY = 0,
  parameter int unsigned TIMEOUT      = 255,
  parameter logic        AUTO_START   = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        pass,
  output logic        timeout_err,
  output logic [31:0] sys_id,
  output logic [31:0] sys_ts
);

  sysid_state_t state, next_state;

  logic req, lat, word_ts;
  logic accept, capture, timeout;
  logic run_start;
  logic auto_arm;
  logic id_valid, ts_valid;
  logic id_match, ts_match, cmp_ready;

  avm_single_read #(
    .READ_LATENCY (READ_LATENCY),
    .TIMEOUT      (TIMEOUT)
  ) u_read (
    .clock       (clock),
    .reset       (reset),
    .req         (req),
    .lat         (lat),
    .waitrequest (avm_waitrequest),
    .accept      (accept),
    .capture     (capture),
    .timeout     (timeout)
  );

  always_comb begin
    req         = (state == ST_REQ_ID) || (state == ST_REQ_TS);
    lat         = (state == ST_LAT_ID) || (state == ST_LAT_TS);
    word_ts     = (state == ST_REQ_TS) || (state == ST_LAT_TS);
    avm_read    = req;
    avm_address = word_ts ? SYSID_TS_OFS : SYSID_ID_OFS;
    run_start   = (state == ST_IDLE) && (start || auto_arm);
  end

  always_comb begin
    next_state = state;
    unique case (state)
      ST_IDLE: begin
        if (run_start) next_state = ST_REQ_ID;
      end
      ST_REQ_ID: begin
        if (timeout) begin
          next_state = ST_FIN;
        end else if (accept) begin
          next_state = (READ_LATENCY == 0) ? ST_REQ_TS : ST_LAT_ID;
        end
      end
      ST_LAT_ID: begin
        if (capture) next_state = ST_REQ_TS;
      end
      ST_REQ_TS: begin
        if (timeout) begin
          next_state = ST_FIN;
        end else if (accept) begin
          next_state = (READ_LATENCY == 0) ? ST_FIN : ST_LAT_TS;
        end
      end
      ST_LAT_TS: begin
        if (capture) next_state = ST_FIN;
      end
      ST_FIN: begin
        if (cmp_ready) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_IDLE;
      auto_arm    <= AUTO_START;
      busy        <= 1'b0;
      done        <= 1'b0;
      id_ok       <= 1'b0;
      ts_ok       <= 1'b0;
      pass        <= 1'b0;
      timeout_err <= 1'b0;
      sys_id      <= '0;
      sys_ts      <= '0;
      id_valid    <= 1'b0;
      ts_valid    <= 1'b0;
      id_match    <= 1'b0;
      ts_match    <= 1'b0;
      cmp_ready   <= 1'b0;
    end else begin
      state <= next_state;
      done  <= 1'b0;

      if (run_start) begin
        auto_arm    <= 1'b0;
        busy        <= 1'b1;
        id_ok       <= 1'b0;
        ts_ok       <= 1'b0;
        pass        <= 1'b0;
        timeout_err <= 1'b0;
        id_valid    <= 1'b0;
        ts_valid    <= 1'b0;
        cmp_ready   <= 1'b0;
      end

      if (capture && !word_ts) begin
        sys_id   <= avm_readdata;
        id_valid <= 1'b1;
      end
      if (capture && word_ts) begin
        sys_ts   <= avm_readdata;
        ts_valid <= 1'b1;
      end

      if (timeout) timeout_err <= 1'b1;

      // FIN spends one cycle registering the compares, a second publishing them.
      if (state == ST_FIN) begin
        if (!cmp_ready) begin
          id_match  <= word_match(id_valid, sys_id, EXPECTED_ID);
          ts_match  <= word_match(ts_valid, sys_ts, EXPECTED_TS);
          cmp_ready <= 1'b1;
        end else begin
          id_ok     <= id_match;
          ts_ok     <= ts_match;
          pass      <= id_match && ts_match && !timeout_err;
          done      <= 1'b1;
          busy      <= 1'b0;
          cmp_ready <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_sysid_checker.sv
// Directed bench for sysid_checker: a zero-latency instance and a
// two-cycle-latency / short-timeout instance, each fed by a small slave model.
module tb_sysid_checker;

  localparam logic [31:0] TS_VAL = 32'd1427079909;

  logic        clk;
  logic        rst        [2];
  logic        start      [2];
  logic        addr       [2];
  logic        rd         [2];
  logic        wreq       [2];
  logic [31:0] rdata      [2];
  logic        busy       [2];
  logic        done       [2];
  logic        id_ok      [2];
  logic        ts_ok      [2];
  logic        pass       [2];
  logic        terr       [2];
  logic [31:0] sys_id     [2];
  logic [31:0] sys_ts     [2];

  // slave model controls
  logic [31:0] mem_id     [2];
  logic [31:0] mem_ts     [2];
  int          stall_n    [2];
  logic        stuck_ts   [2];
  int          stab_err   [2];

  int n_checks = 0;
  int n_fail   = 0;

  sysid_checker #(
    .AUTO_START (1'b1)
  ) u_dut_a (
    .clock (clk), .reset (rst[0]), .start (start[0]),
    .avm_address (addr[0]), .avm_read (rd[0]), .avm_waitrequest (wreq[0]),
    .avm_readdata (rdata[0]), .busy (busy[0]), .done (done[0]),
    .id_ok (id_ok[0]), .ts_ok (ts_ok[0]), .pass (pass[0]),
    .timeout_err (terr[0]), .sys_id (sys_id[0]), .sys_ts (sys_ts[0])
  );

  sysid_checker #(
    .READ_LATENCY (2),
    .TIMEOUT      (8)
  ) u_dut_b (
    .clock (clk), .reset (rst[1]), .start (start[1]),
    .avm_address (addr[1]), .avm_read (rd[1]), .avm_waitrequest (wreq[1]),
    .avm_readdata (rdata[1]), .busy (busy[1]), .done (done[1]),
    .id_ok (id_ok[1]), .ts_ok (ts_ok[1]), .pass (pass[1]),
    .timeout_err (terr[1]), .sys_id (sys_id[1]), .sys_ts (sys_ts[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slave model, updated on the falling edge. A read is accepted in a cycle
  // with read & ~waitrequest; its data appears LAT cycles later, garbage otherwise.
  int          cyc        = 0;
  int          scnt       [2] = '{0, 0};
  logic        pend_v     [2] = '{1'b0, 1'b0};
  logic        pend_a     [2] = '{1'b0, 1'b0};
  int          pend_due   [2] = '{0, 0};
  logic        prev_rd    [2] = '{1'b0, 1'b0};
  logic        prev_w     [2] = '{1'b0, 1'b0};
  logic        prev_a     [2] = '{1'b0, 1'b0};

  always @(negedge clk) begin
    logic w;
    for (int i = 0; i < 2; i++) begin
      if (!rst[i] && prev_w[i] && prev_rd[i]) begin
        if (rd[i] ? (addr[i] != prev_a[i]) : !terr[i]) stab_err[i]++;
      end
      w = 1'b0;
      if (rd[i]) begin
        if (stuck_ts[i] && addr[i]) begin
          w = 1'b1;
        end else if (scnt[i] < stall_n[i]) begin
          w = 1'b1;
          scnt[i]++;
        end else begin
          scnt[i] = 0;
        end
      end else begin
        scnt[i] = 0;
      end
      wreq[i] = w;
      if (rd[i] && !w) begin
        pend_v[i]   = 1'b1;
        pend_a[i]   = addr[i];
        pend_due[i] = cyc + ((i == 1) ? 2 : 0);
      end
      if (pend_v[i] && pend_due[i] == cyc) begin
        rdata[i]  = pend_a[i] ? mem_ts[i] : mem_id[i];
        pend_v[i] = 1'b0;
      end else begin
        rdata[i] = 32'hA5A5_0000 | 32'(cyc[15:0]);
      end
      prev_rd[i] = rd[i];
      prev_w[i]  = w;
      prev_a[i]  = addr[i];
    end
    cyc++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Assert reset for one edge, check cleared outputs, release; returns just
  // after the edge that takes the auto-start.
  task automatic reset_release(input int i);
    @(negedge clk);
    rst[i] = 1'b1;
    @(posedge clk); #1;
    check_eq("rst_done",  32'(done[i]),  32'd0);
    check_eq("rst_busy",  32'(busy[i]),  32'd0);
    check_eq("rst_pass",  32'(pass[i]),  32'd0);
    check_eq("rst_id_ok", 32'(id_ok[i]), 32'd0);
    check_eq("rst_ts_ok", 32'(ts_ok[i]), 32'd0);
    check_eq("rst_terr",  32'(terr[i]),  32'd0);
    check_eq("rst_read",  32'(rd[i]),    32'd0);
    check_eq("rst_addr",  32'(addr[i]),  32'd0);
    check_eq("rst_sys_id", sys_id[i],    32'd0);
    check_eq("rst_sys_ts", sys_ts[i],    32'd0);
    @(negedge clk);
    rst[i] = 1'b0;
    @(posedge clk); #1;
    check_eq("auto_busy", 32'(busy[i]), 32'd1);
  endtask

  // Returns just after the edge that samples start.
  task automatic pulse_start(input int i);
    @(negedge clk);
    start[i] = 1'b1;
    @(posedge clk); #1;
    start[i] = 1'b0;
  endtask

  // Edges from the start-sampling edge until done is seen; -1 when the bound expires.
  task automatic wait_done(input int i, input int max, output int edges);
    edges = -1;
    for (int k = 1; k <= max; k++) begin
      @(posedge clk); #1;
      if (done[i]) begin
        edges = k;
        break;
      end
    end
  endtask

  int e;
  int ndone;

  initial begin
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; start[i] = 1'b0; wreq[i] = 1'b0; rdata[i] = '0;
      mem_id[i] = 32'd0; mem_ts[i] = TS_VAL;
      stall_n[i] = 0; stuck_ts[i] = 1'b0; stab_err[i] = 0;
    end
    repeat (3) @(posedge clk);

    // auto-start, zero latency: done on the 4th edge after the start edge
    reset_release(0);
    wait_done(0, 50, e);
    check_eq("a_auto_lat", 32'(e), 32'd4);
    check_eq("a_pass",   32'(pass[0]),  32'd1);
    check_eq("a_id_ok",  32'(id_ok[0]), 32'd1);
    check_eq("a_ts_ok",  32'(ts_ok[0]), 32'd1);
    check_eq("a_terr",   32'(terr[0]),  32'd0);
    check_eq("a_busy",   32'(busy[0]),  32'd0);
    check_eq("a_sys_ts", sys_ts[0], TS_VAL);
    check_eq("a_sys_id", sys_id[0], 32'd0);
    @(posedge clk); #1;
    check_eq("a_done_pulse", 32'(done[0]), 32'd0);
    check_eq("a_hold_pass",  32'(pass[0]), 32'd1);

    // ID mismatch
    mem_id[0] = 32'h1234_5678;
    pulse_start(0);
    wait_done(0, 50, e);
    check_eq("mm_lat",    32'(e), 32'd4);
    check_eq("mm_id_ok",  32'(id_ok[0]), 32'd0);
    check_eq("mm_ts_ok",  32'(ts_ok[0]), 32'd1);
    check_eq("mm_pass",   32'(pass[0]),  32'd0);
    check_eq("mm_sys_id", sys_id[0], 32'h1234_5678);

    // 10 stall cycles per read: 20 cycles later than the no-stall case
    mem_id[0]  = 32'd0;
    stall_n[0] = 10;
    pulse_start(0);
    wait_done(0, 100, e);
    check_eq("st_lat",  32'(e), 32'd24);
    check_eq("st_pass", 32'(pass[0]), 32'd1);
    check_eq("st_stable", 32'(stab_err[0]), 32'd0);

    // start while busy is dropped: exactly one done
    stall_n[0] = 3;
    pulse_start(0);
    repeat (2) @(posedge clk);
    #1;
    check_eq("rs_busy", 32'(busy[0]), 32'd1);
    pulse_start(0);
    ndone = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done[0]) ndone++;
    end
    check_eq("rs_ndone", 32'(ndone), 32'd1);
    check_eq("rs_pass",  32'(pass[0]), 32'd1);
    stall_n[0] = 0;

    // READ_LATENCY=2 instance
    reset_release(1);
    wait_done(1, 50, e);
    check_eq("l2_lat",    32'(e), 32'd8);
    check_eq("l2_pass",   32'(pass[1]), 32'd1);
    check_eq("l2_sys_id", sys_id[1], 32'd0);
    check_eq("l2_sys_ts", sys_ts[1], TS_VAL);

    // timeout on word 1 after 8 stall cycles
    stuck_ts[1] = 1'b1;
    pulse_start(1);
    wait_done(1, 50, e);
    check_eq("to_lat",   32'(e), 32'd13);
    check_eq("to_terr",  32'(terr[1]),  32'd1);
    check_eq("to_id_ok", 32'(id_ok[1]), 32'd1);
    check_eq("to_ts_ok", 32'(ts_ok[1]), 32'd0);
    check_eq("to_pass",  32'(pass[1]),  32'd0);
    check_eq("to_read",  32'(rd[1]),    32'd0);
    @(posedge clk); #1;
    check_eq("to_done_pulse", 32'(done[1]), 32'd0);
    stuck_ts[1] = 1'b0;

    // reset while in LAT_TS, then a fresh auto-start
    pulse_start(1);
    repeat (4) @(posedge clk);
    #1;
    check_eq("lt_addr", 32'(addr[1]), 32'd1);
    check_eq("lt_read", 32'(rd[1]),   32'd0);
    check_eq("lt_terr", 32'(terr[1]), 32'd0);
    reset_release(1);
    wait_done(1, 50, e);
    check_eq("rr_lat",  32'(e), 32'd8);
    check_eq("rr_pass", 32'(pass[1]), 32'd1);
    check_eq("b_stable", 32'(stab_err[1]), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
